// File: rtl/unified_mem_arbiter_pkg.sv
// Shared state and owner encodings for the unified I/D memory arbiter.
// The CPU stall logic imports these to decode the arbiter's registered state.
package unified_mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/arb_timeout_counter.sv
// Clear/enable cycle counter; 'expired' is high while enabled at TIMEOUT-1.
module arb_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between fetch (I) and MEM-stage (D) ports.
// One transaction in flight; grant and response routing are combinational.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e    state, state_nxt;
  arb_owner_e    owner, owner_nxt;
  logic          owner_we, owner_we_nxt;
  logic [SW-1:0] starve_cnt;
  logic          i_wins;
  logic          tmo_expired;
  logic          tmo_abort;
  logic          tmo_clr;
  logic          tmo_en;

  // D normally wins (older instruction); a starved fetch overrides it.
  assign i_wins = i_req && (!d_req || (starve_cnt == SW'(STARVE_MAX)));

  assign tmo_en    = (state == ST_WAIT);
  assign tmo_clr   = (state != ST_WAIT) || m_rvalid || tmo_expired;
  assign tmo_abort = (state == ST_WAIT) && !m_rvalid && tmo_expired;
  assign busy      = (state == ST_WAIT);

  arb_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    owner_we_nxt = owner_we;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    i_rvalid     = 1'b0;
    i_rdata      = '0;
    d_rvalid     = 1'b0;
    d_rdata      = '0;
    m_req        = 1'b0;
    m_we         = 1'b0;
    m_addr       = '0;
    m_wdata      = '0;
    case (state)
      ST_IDLE: begin
        if (i_req || d_req) begin
          m_req     = 1'b1;
          state_nxt = ST_WAIT;
          if (i_wins) begin
            i_gnt        = 1'b1;
            m_addr       = i_addr;
            owner_nxt    = OWN_I;
            owner_we_nxt = 1'b0;
          end else begin
            d_gnt        = 1'b1;
            m_we         = d_we;
            m_addr       = d_addr;
            m_wdata      = d_wdata;
            owner_nxt    = OWN_D;
            owner_we_nxt = d_we;
          end
        end
      end
      ST_WAIT: begin
        if (m_rvalid) begin
          if (owner == OWN_I) begin
            i_rvalid = 1'b1;
            i_rdata  = m_rdata;
          end else if (owner == OWN_D) begin
            d_rvalid = 1'b1;
            d_rdata  = owner_we ? '0 : m_rdata;
          end
          state_nxt = ST_IDLE;
          owner_nxt = OWN_NONE;
        end else if (tmo_expired) begin
          state_nxt = ST_IDLE;
          owner_nxt = OWN_NONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      owner    <= OWN_NONE;
      owner_we <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      owner_we <= owner_we_nxt;
      if (tmo_abort) err <= 1'b1;
    end
  end

  // Any cycle without a pending fetch means nothing is being starved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (!i_req || i_gnt)
      starve_cnt <= '0;
    else if (d_gnt && (starve_cnt != SW'(STARVE_MAX)))
      starve_cnt <= starve_cnt + 1'b1;
  end

endmodule
